// File: rtl/enc_input_cond_if.sv
// Encoder raw-line inputs and conditioned/decoded outputs between the pad side
// and the phase-measurement stage.
interface enc_input_cond_if #(
    parameter int POS_W = 16
);
    logic             encA_in;
    logic             encB_in;
    logic             encA;
    logic             encB;
    logic             riseA;
    logic             riseB;
    logic             dir;
    logic [POS_W-1:0] pos;
    logic             err;

    modport master (
        output encA_in, encB_in,
        input  encA, encB, riseA, riseB, dir, pos, err
    );

    modport slave (
        input  encA_in, encB_in,
        output encA, encB, riseA, riseB, dir, pos, err
    );
endinterface

// File: rtl/enc_input_cond.sv
// Encoder input conditioning: 2-FF sync + glitch filter per channel, rise strobes,
// and quadrature decode into direction, wrapping position and sticky error.
module enc_filt_ch #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic lvl,
    output logic rise
);
    logic       s1, s2;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= 8'd0;
            lvl  <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 == lvl) begin
                cnt <= 8'd0;
            end else if (cnt == 8'(FILT_LEN - 1)) begin
                // s2 has disagreed with the output for FILT_LEN samples: accept it
                lvl  <= s2;
                rise <= s2;
                cnt  <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule

module enc_input_cond #(
    parameter int FILT_LEN = 4,
    parameter int POS_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    enc_input_cond_if.slave  bus
);
    localparam int NUM_CH = 2;

    // Channel index 1 = A, 0 = B
    logic [NUM_CH-1:0] raw, lvl, rise;
    logic [NUM_CH-1:0] prev, chg;
    logic              dir_q, err_q;
    logic [POS_W-1:0]  pos_q;

    assign raw = {bus.encA_in, bus.encB_in};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        enc_filt_ch #(.FILT_LEN(FILT_LEN)) u_filt (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw[c]),
            .lvl  (lvl[c]),
            .rise (rise[c])
        );
    end

    assign chg = lvl ^ prev;

    // Along 00->10->11->01 the new A always differs from the old B when moving forward
    always_ff @(posedge clk) begin
        if (rst) begin
            prev  <= '0;
            dir_q <= 1'b0;
            err_q <= 1'b0;
            pos_q <= '0;
        end else begin
            prev <= lvl;
            if (chg == 2'b11) begin
                err_q <= 1'b1;
            end else if (chg != 2'b00) begin
                if (lvl[1] ^ prev[0]) begin
                    pos_q <= pos_q + POS_W'(1);
                    dir_q <= 1'b1;
                end else begin
                    pos_q <= pos_q - POS_W'(1);
                    dir_q <= 1'b0;
                end
            end
        end
    end

    assign bus.encA  = lvl[1];
    assign bus.encB  = lvl[0];
    assign bus.riseA = rise[1];
    assign bus.riseB = rise[0];
    assign bus.dir   = dir_q;
    assign bus.pos   = pos_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_enc_input_cond.sv
// Randomized + directed bench for enc_input_cond with a queue-based scoreboard
// fed by a cycle-level behavioural model.
module tb_enc_input_cond;
    localparam int L  = 4;
    localparam int PW = 16;

    typedef struct packed {
        logic          ea, eb, ra, rb, dir;
        logic [PW-1:0] pos;
        logic          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    enc_input_cond_if #(.POS_W(PW)) bus ();

    enc_input_cond #(.FILT_LEN(L), .POS_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Model state: filtered levels, previous levels, raw delay line, sample history
    bit [1:0]   m_enc, m_prev, m_s1, m_s2;
    bit [255:0] hist [2];
    int         nseen [2];
    bit         m_dir, m_err;
    bit [PW-1:0] m_pos;

    // Position of a {A,B} pair along the forward cycle 00,10,11,01
    function automatic int qidx(input bit [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_edge(input bit r, input bit [1:0] raw, output exp_t e);
        bit [1:0] rs;
        bit       ok;
        int       d;
        rs = 2'b00;
        if (r) begin
            m_enc = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
            m_dir = 0; m_err = 0; m_pos = 0;
            for (int c = 0; c < 2; c++) begin
                hist[c]  = '0;
                nseen[c] = 0;
            end
        end else begin
            d = (qidx(m_enc) - qidx(m_prev) + 4) % 4;
            if (d == 1) begin m_pos = m_pos + 1; m_dir = 1; end
            else if (d == 3) begin m_pos = m_pos - 1; m_dir = 0; end
            else if (d == 2) m_err = 1;
            m_prev = m_enc;
            for (int c = 0; c < 2; c++) begin
                hist[c] = {hist[c][254:0], m_s2[c]};
                if (nseen[c] < 255) nseen[c]++;
                ok = (nseen[c] >= L);
                for (int i = 0; i < L; i++)
                    if (hist[c][i] == m_enc[c]) ok = 0;
                if (ok) begin
                    m_enc[c] = ~m_enc[c];
                    rs[c]    = m_enc[c];
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
        end
        e = '{ea: m_enc[1], eb: m_enc[0], ra: rs[1], rb: rs[0],
              dir: m_dir, pos: m_pos, err: m_err};
    endtask

    task automatic step(input bit r, input bit a, input bit b);
        exp_t e;
        @(negedge clk);
        rst         = r;
        bus.encA_in = a;
        bus.encB_in = b;
        model_edge(r, {a, b}, e);
        exp_q.push_back(e);
    endtask

    task automatic hold(input bit a, input bit b, input int n);
        for (int i = 0; i < n; i++) step(1'b0, a, b);
    endtask

    task automatic chk(input string name, input logic [PW-1:0] got, input logic [PW-1:0] want);
        @(posedge clk);
        #1;
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    always @(posedge clk) begin
        exp_t e, g;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{ea: bus.encA, eb: bus.encB, ra: bus.riseA, rb: bus.riseB,
                  dir: bus.dir, pos: bus.pos, err: bus.err};
            n_vec++;
            if (g !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t got ea=%b eb=%b ra=%b rb=%b dir=%b pos=%h err=%b want ea=%b eb=%b ra=%b rb=%b dir=%b pos=%h err=%b",
                         $time, g.ea, g.eb, g.ra, g.rb, g.dir, g.pos, g.err,
                         e.ea, e.eb, e.ra, e.rb, e.dir, e.pos, e.err);
            end
        end
    end

    bit [1:0] fwd_seq [4];
    int       ph;
    int       rise_a_cnt, rise_b_cnt;

    always @(posedge clk) begin
        #1;
        if (bus.riseA === 1'b1) rise_a_cnt++;
        if (bus.riseB === 1'b1) rise_b_cnt++;
    end

    initial begin
        bit [1:0] cur;
        int       ra0, rb0;
        fwd_seq[0] = 2'b00; fwd_seq[1] = 2'b10; fwd_seq[2] = 2'b11; fwd_seq[3] = 2'b01;
        bus.encA_in = 1'b0;
        bus.encB_in = 1'b0;

        // Reset with raw lines toggling
        step(1, 1, 0); step(1, 0, 1); step(1, 1, 1);
        step(0, 0, 0);

        // Latency: A rises and holds
        hold(1, 0, 10);
        chk("latency_pos", bus.pos, 16'd1);
        chk("latency_dir", {15'd0, bus.dir}, 16'd1);

        // Glitch rejection: 3-cycle pulse ignored, 4-cycle pulse accepted
        step(1, 0, 0);
        hold(0, 0, 3); hold(1, 0, 3); hold(0, 0, 10);
        chk("glitch3_pos", bus.pos, 16'd0);
        hold(1, 0, 4); hold(0, 0, 12);
        chk("pulse4_pos", bus.pos, 16'd0);
        chk("pulse4_err", {15'd0, bus.err}, 16'd0);

        // 16 forward transitions then 3 reverse
        step(1, 0, 0);
        hold(0, 0, 3);
        ra0 = rise_a_cnt; rb0 = rise_b_cnt;
        ph = 0;
        for (int i = 0; i < 16; i++) begin
            ph  = (ph + 1) % 4;
            cur = fwd_seq[ph];
            hold(cur[1], cur[0], 10);
        end
        chk("fwd_pos", bus.pos, 16'd16);
        chk("fwd_dir", {15'd0, bus.dir}, 16'd1);
        chk("fwd_err", {15'd0, bus.err}, 16'd0);
        chk("fwd_riseA", 16'(rise_a_cnt - ra0), 16'd4);
        chk("fwd_riseB", 16'(rise_b_cnt - rb0), 16'd4);
        for (int i = 0; i < 3; i++) begin
            ph  = (ph + 3) % 4;
            cur = fwd_seq[ph];
            hold(cur[1], cur[0], 10);
        end
        chk("rev_pos", bus.pos, 16'd13);
        chk("rev_dir", {15'd0, bus.dir}, 16'd0);

        // Wrap below zero and back
        step(1, 0, 0);
        hold(0, 0, 3);
        hold(0, 1, 10);
        chk("wrap_neg", bus.pos, 16'hFFFF);
        hold(0, 0, 10);
        chk("wrap_zero", bus.pos, 16'd0);

        // Illegal double change, sticky error, legal steps still count
        step(1, 0, 0);
        hold(0, 0, 3);
        hold(1, 1, 10);
        chk("illegal_err", {15'd0, bus.err}, 16'd1);
        chk("illegal_pos", bus.pos, 16'd0);
        hold(0, 1, 10);
        hold(0, 0, 10);
        chk("sticky_err", {15'd0, bus.err}, 16'd1);
        chk("sticky_pos", bus.pos, 16'd2);
        step(1, 0, 0);
        hold(0, 0, 2);
        chk("err_cleared", {15'd0, bus.err}, 16'd0);

        // Random segments: arbitrary levels, short/long holds, occasional reset
        for (int s = 0; s < 600; s++) begin
            bit a, b;
            int n;
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 9);
            if ($urandom_range(0, 63) == 0) step(1, a, b);
            hold(a, b, n);
        end
        hold(0, 0, 12);

        repeat (4) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
